dbi_rx_phy: RTL and testbench
=============================

Name: dbi_rx_phy

Overview:
- Receive-side PHY for the MIPI DBI Type-B (8080-style) write interface; the counterpart of the DBI TX PHY.
- Samples the asynchronous DBI pins (CSX, DCX, WRX, RDX, RESX, D) in the internal clock domain.
- Frames each CSX-low window into a command byte followed by parameter bytes, and delivers them as a valid/ready byte stream with command and last markers.
- Used as the display-side bus model and as the front end of the panel-emulation path.

Parameters:
- DBI_IF_D_W, 8, DBI data bus width.
- FIFO_DEPTH, 4, output FIFO entries; power of 2, ≥2.
- RESX_MIN_CYC, 1250, minimum synced RESX-low cycles recognised as a hardware reset (10 us at 125 MHz).

Ports:
- clk  in  1  internal clock.
- rst  in  1  synchronous, active-high reset.
- dbi_d_i  in  DBI_IF_D_W  DBI data pins (asynchronous).
- dbi_csx_i  in  1  chip select, active low.
- dbi_dcx_i  in  1  0 = command, 1 = parameter/data.
- dbi_wrx_i  in  1  write strobe; data is sampled on its rising edge.
- dbi_rdx_i  in  1  read strobe; reads are unsupported.
- dbi_resx_i  in  1  panel reset, active low.
- rx_dat_o  out  DBI_IF_D_W  received byte.
- rx_cmd_o  out  1  byte is a command (DCX was 0).
- rx_last_o  out  1  last byte of the CSX window.
- rx_vld_o  out  1  output stream valid.
- rx_rdy_i  in  1  downstream ready.
- hrst_o  out  1  one-cycle pulse when a qualified hardware reset is released.
- err_o  out  1  sticky protocol error.
- ovf_o  out  1  sticky FIFO overflow.
- err_clr_i  in  1  clears err_o and ovf_o.

Behaviour:
- Reset: clk-synchronous, active-high, with the single clock clk.
  - All sync flops load the idle level: CSX/WRX/RDX/RESX = 1, DCX = 1, D = 0.
  - FSM goes to IDLE; hold register is empty; FIFO is emptied.
  - All outputs are 0 (rx_dat_o = 0).
- Synchronisation:
  - Every DBI input passes through a 2-flop synchroniser, then one further delay register (wrx_d, csx_d).
  - WRX rise event = wrx_s & ~wrx_d; CSX rise event = csx_s & ~csx_d.
  - Byte and DCX are taken from the synced D/DCX in the WRX-rise cycle.
  - Pin low/high times ≥ 3 clk periods are guaranteed to be captured.
- Hold register: one entry (byte, cmd) plus a full flag. A byte is emitted only once the next event proves whether it is last.
- FSM states: IDLE, ACTIVE, PARAM, HRST.
  - IDLE: wait for csx_s = 0, then go to ACTIVE. WRX rises while CSX is high are ignored.
  - ACTIVE (no command yet):
    - WRX rise with DCX = 0: load the hold register with cmd = 1, go to PARAM.
    - WRX rise with DCX = 1: drop the byte, set err_o.
    - CSX rise: go to IDLE.
  - PARAM:
    - WRX rise: push the held byte with last = 0, load the new byte (cmd = ~dcx_s).
    - CSX rise: push the held byte with last = 1, clear the hold register, go to IDLE.
    - WRX rise and CSX rise in the same cycle: capture the new byte, push the held byte (last = 0), then push the new byte (last = 1) on the next cycle. Move to IDLE after the second push.
  - Any state, resx_s = 0:
    - Discard the hold register (FIFO contents are kept) and go to HRST.
    - A 16-bit-capable counter counts low cycles, saturating at RESX_MIN_CYC.
  - HRST: on resx_s = 1, pulse hrst_o for 1 cycle only if the count reached RESX_MIN_CYC, else set err_o. Go to IDLE, or ACTIVE if csx_s = 0.
  - RDX falling while csx_s = 0: set err_o. No other effect.
- FIFO:
  - Show-ahead; rx_vld_o = ~empty, data/cmd/last come from the head entry.
  - A push becomes visible on rx_vld_o the cycle after the push cycle. Push-to-pin latency: WRX pin rise to hold ≈ 3 clk.
  - Pop on rx_vld_o & rx_rdy_i. Simultaneous push and pop when full is allowed and is not an overflow.
  - Push when full without a pop: drop the pushed byte, set ovf_o. The FSM continues.
- Sticky flags: err_o and ovf_o stay set until err_clr_i. A new set in the same cycle as the clear wins.

Test Plan:
- Reset state: hold rst = 1 for 2 cycles with all pins idle → all outputs 0, rx_vld_o = 0.
- Command with 2 parameters: CSX low; write 0x2A (DCX = 0), then 0x00 and 0xEF (DCX = 1) with WRX 4 low / 4 high cycles; CSX high, rx_rdy_i = 1 → stream {0x2A, cmd = 1, last = 0}, {0x00, 0, 0}, {0xEF, 0, 1}; err_o = 0.
- Command only: write 0x29 (DCX = 0), then CSX high → exactly one beat {0x29, cmd = 1, last = 1}.
- Protocol errors:
  - First byte 0x55 with DCX = 1 → no output beat, err_o = 1.
  - err_clr_i pulse → err_o = 0.
  - RDX low inside CSX-low → err_o = 1.
- Overflow: rx_rdy_i = 0, FIFO_DEPTH = 4, send a command plus 5 parameters and close CSX → 4 beats retained (0x2C, p0, p1, p2), ovf_o = 1. With rx_rdy_i = 1 they drain in order.
- Hardware reset:
  - RESX low 1250 cycles mid-parameter → held byte discarded, hrst_o pulses once after release.
  - RESX low 100 cycles → no hrst_o, err_o = 1.

Source files
------------

// File: rtl/dbi_rx_phy.sv
// sync_fifo: generic single-clock show-ahead FIFO (head entry always visible on rd_dat).
// Latency: a write is visible on rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy drops when full unless the head is popped in the same cycle.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    output logic         wr_rdy,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_wr;
    logic          do_rd;

    assign rd_vld = (cnt != '0);
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_rdy = (cnt != FULL_CNT) || rd_rdy;
    assign do_wr  = wr_vld && wr_rdy;
    assign do_rd  = rd_vld && rd_rdy;
    assign rd_dat = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_dat;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt <= cnt + (AW+1)'(1);
                2'b01:   cnt <= cnt - (AW+1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// dbi_rx_phy: DBI Type-B (8080) write receiver; frames each CSX-low window into a cmd + param byte stream.
// Latency: ~4 clk from a WRX/CSX pin rise to the FIFO push, +1 clk to rx_vld_o.
// Backpressure: rx_rdy_i low fills the FIFO; further pushes are dropped and flagged on sticky ovf_o.
module dbi_rx_phy #(
    parameter int DBI_IF_D_W   = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int RESX_MIN_CYC = 1250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DBI_IF_D_W-1:0] dbi_d_i,
    input  logic                  dbi_csx_i,
    input  logic                  dbi_dcx_i,
    input  logic                  dbi_wrx_i,
    input  logic                  dbi_rdx_i,
    input  logic                  dbi_resx_i,
    output logic [DBI_IF_D_W-1:0] rx_dat_o,
    output logic                  rx_cmd_o,
    output logic                  rx_last_o,
    output logic                  rx_vld_o,
    input  logic                  rx_rdy_i,
    output logic                  hrst_o,
    output logic                  err_o,
    output logic                  ovf_o,
    input  logic                  err_clr_i
);
    typedef struct packed {
        logic [DBI_IF_D_W-1:0] dat;
        logic                  cmd;
        logic                  last;
    } rx_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_PARAM,
        ST_HRST
    } state_t;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] RESX_MIN = CNT_W'(RESX_MIN_CYC);
    localparam int BEAT_W = DBI_IF_D_W + 2;

    // Synchroniser stages (_m = metastable stage, _s = synced, _d = one more delay for edge detect)
    logic [DBI_IF_D_W-1:0] d_m, d_s;
    logic csx_m, csx_s, csx_d;
    logic dcx_m, dcx_s;
    logic wrx_m, wrx_s, wrx_d;
    logic rdx_m, rdx_s, rdx_d;
    logic resx_m, resx_s;

    logic wrx_rise;
    logic csx_rise;
    logic rdx_fall;

    state_t                state;
    logic [DBI_IF_D_W-1:0] hold_dat;
    logic                  hold_cmd;
    logic                  hold_full;
    logic                  flush_pend;
    logic [CNT_W-1:0]      resx_cnt;
    logic                  push_vld;
    rx_beat_t              push_beat;

    logic                  fifo_wr_rdy;
    logic                  fifo_rd_vld;
    logic [BEAT_W-1:0]     fifo_rd_dat;
    rx_beat_t              head;

    // Bring every DBI pin into clk; reset loads the idle bus levels so no false edges follow reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_m    <= '0;
            d_s    <= '0;
            csx_m  <= 1'b1;
            csx_s  <= 1'b1;
            csx_d  <= 1'b1;
            dcx_m  <= 1'b1;
            dcx_s  <= 1'b1;
            wrx_m  <= 1'b1;
            wrx_s  <= 1'b1;
            wrx_d  <= 1'b1;
            rdx_m  <= 1'b1;
            rdx_s  <= 1'b1;
            rdx_d  <= 1'b1;
            resx_m <= 1'b1;
            resx_s <= 1'b1;
        end else begin
            d_m    <= dbi_d_i;
            d_s    <= d_m;
            csx_m  <= dbi_csx_i;
            csx_s  <= csx_m;
            csx_d  <= csx_s;
            dcx_m  <= dbi_dcx_i;
            dcx_s  <= dcx_m;
            wrx_m  <= dbi_wrx_i;
            wrx_s  <= wrx_m;
            wrx_d  <= wrx_s;
            rdx_m  <= dbi_rdx_i;
            rdx_s  <= rdx_m;
            rdx_d  <= rdx_s;
            resx_m <= dbi_resx_i;
            resx_s <= resx_m;
        end
    end

    assign wrx_rise = wrx_s & ~wrx_d;
    assign csx_rise = csx_s & ~csx_d;
    assign rdx_fall = ~rdx_s & rdx_d;

    // Framing FSM: a byte sits in the hold register until the next WRX or CSX rise tells us whether it was last.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold_dat   <= '0;
            hold_cmd   <= 1'b0;
            hold_full  <= 1'b0;
            flush_pend <= 1'b0;
            resx_cnt   <= '0;
            push_vld   <= 1'b0;
            push_beat  <= '0;
            hrst_o     <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            push_vld <= 1'b0;
            hrst_o   <= 1'b0;
            // Clear first so that any error raised below in the same cycle survives.
            if (err_clr_i) err_o <= 1'b0;
            if (rdx_fall && !csx_s) err_o <= 1'b1;

            if (!resx_s) begin
                // Panel reset wins over everything: drop the held byte, keep what is already queued.
                hold_full  <= 1'b0;
                flush_pend <= 1'b0;
                if (state != ST_HRST) begin
                    state    <= ST_HRST;
                    resx_cnt <= CNT_W'(1);
                end else if (resx_cnt < RESX_MIN) begin
                    resx_cnt <= resx_cnt + CNT_W'(1);
                end
            end else if (flush_pend) begin
                // Second half of a WRX rise coinciding with the CSX rise: the just-captured byte closes the window.
                push_vld   <= 1'b1;
                push_beat  <= '{dat: hold_dat, cmd: hold_cmd, last: 1'b1};
                hold_full  <= 1'b0;
                flush_pend <= 1'b0;
                state      <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (!csx_s) state <= ST_ACTIVE;
                    end
                    ST_ACTIVE: begin
                        if (wrx_rise) begin
                            if (!dcx_s) begin
                                hold_dat  <= d_s;
                                hold_cmd  <= 1'b1;
                                hold_full <= 1'b1;
                                state     <= ST_PARAM;
                                if (csx_rise) flush_pend <= 1'b1;
                            end else begin
                                // A window must open with a command; stray data is dropped.
                                err_o <= 1'b1;
                                if (csx_rise) state <= ST_IDLE;
                            end
                        end else if (csx_rise) begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_PARAM: begin
                        if (wrx_rise) begin
                            if (hold_full) begin
                                push_vld  <= 1'b1;
                                push_beat <= '{dat: hold_dat, cmd: hold_cmd, last: 1'b0};
                            end
                            hold_dat  <= d_s;
                            hold_cmd  <= ~dcx_s;
                            hold_full <= 1'b1;
                            if (csx_rise) flush_pend <= 1'b1;
                        end else if (csx_rise) begin
                            push_vld  <= hold_full;
                            push_beat <= '{dat: hold_dat, cmd: hold_cmd, last: 1'b1};
                            hold_full <= 1'b0;
                            state     <= ST_IDLE;
                        end
                    end
                    ST_HRST: begin
                        // RESX released: only a long enough low time counts as a real hardware reset.
                        if (resx_cnt >= RESX_MIN) hrst_o <= 1'b1;
                        else                      err_o  <= 1'b1;
                        resx_cnt <= '0;
                        state    <= csx_s ? ST_IDLE : ST_ACTIVE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Sticky overflow: a push that finds the FIFO full with no simultaneous pop is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
        end else begin
            if (err_clr_i) ovf_o <= 1'b0;
            if (push_vld && !fifo_wr_rdy) ovf_o <= 1'b1;
        end
    end

    sync_fifo #(
        .W     (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (push_vld),
        .wr_rdy (fifo_wr_rdy),
        .wr_dat (push_beat),
        .rd_vld (fifo_rd_vld),
        .rd_rdy (rx_rdy_i),
        .rd_dat (fifo_rd_dat)
    );

    assign head      = rx_beat_t'(fifo_rd_dat);
    assign rx_vld_o  = fifo_rd_vld;
    // Head fields are forced to zero while empty so the outputs are clean after reset.
    assign rx_dat_o  = fifo_rd_vld ? head.dat  : '0;
    assign rx_cmd_o  = fifo_rd_vld ? head.cmd  : 1'b0;
    assign rx_last_o = fifo_rd_vld ? head.last : 1'b0;
endmodule

// File: tb/tb_dbi_rx_phy.sv
// Bench for dbi_rx_phy: drives DBI write windows on the pins and compares the received stream
// against the expected beats derived from the bytes written (first command opens, last byte closes).
module tb_dbi_rx_phy;
    localparam int W     = 8;
    localparam int DEPTH = 4;
    localparam int RMIN  = 1250;

    typedef struct packed {
        logic [W-1:0] dat;
        logic         cmd;
        logic         last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] dbi_d;
    logic         dbi_csx, dbi_dcx, dbi_wrx, dbi_rdx, dbi_resx;
    logic [W-1:0] rx_dat;
    logic         rx_cmd, rx_last, rx_vld, rx_rdy;
    logic         hrst, err, ovf, err_clr;

    logic         rdy_fix;
    bit           rdy_rand_mode;
    logic         rdy_rnd;

    beat_t        got_q[$];
    int           hrst_seen = 0;
    beat_t        win_exp[$];
    logic [W-1:0] win_b[$];
    logic         win_dc[$];
    bit           win_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign rx_rdy = rdy_rand_mode ? rdy_rnd : rdy_fix;

    dbi_rx_phy #(
        .DBI_IF_D_W   (W),
        .FIFO_DEPTH   (DEPTH),
        .RESX_MIN_CYC (RMIN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dbi_d_i    (dbi_d),
        .dbi_csx_i  (dbi_csx),
        .dbi_dcx_i  (dbi_dcx),
        .dbi_wrx_i  (dbi_wrx),
        .dbi_rdx_i  (dbi_rdx),
        .dbi_resx_i (dbi_resx),
        .rx_dat_o   (rx_dat),
        .rx_cmd_o   (rx_cmd),
        .rx_last_o  (rx_last),
        .rx_vld_o   (rx_vld),
        .rx_rdy_i   (rx_rdy),
        .hrst_o     (hrst),
        .err_o      (err),
        .ovf_o      (ovf),
        .err_clr_i  (err_clr)
    );

    // Random downstream ready, changed just after each active edge.
    always @(posedge clk) begin
        #1;
        rdy_rnd = ($urandom_range(0, 3) != 0);
    end

    // Monitor on the falling edge: record accepted beats and hrst_o high cycles.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (rx_vld && rx_rdy) got_q.push_back('{dat: rx_dat, cmd: rx_cmd, last: rx_last});
            if (hrst) hrst_seen++;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr;
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(1);
    endtask

    // Drives one CSX window from win_b/win_dc and derives the beats a correct receiver must emit:
    // bytes before the first command are dropped (error), then every byte is kept with cmd = ~dcx,
    // and the final kept byte carries last.
    task automatic send_window(input bit close_with_last_wr);
        beat_t kept[$];
        beat_t b;
        win_exp.delete();
        win_err = 1'b0;
        dbi_csx = 1'b0;
        cyc(4);
        for (int i = 0; i < win_b.size(); i++) begin
            dbi_dcx = win_dc[i];
            dbi_d   = win_b[i];
            dbi_wrx = 1'b0;
            cyc(4);
            dbi_wrx = 1'b1;
            if (close_with_last_wr && i == win_b.size() - 1) dbi_csx = 1'b1;
            cyc(4);
            if (kept.size() != 0 || win_dc[i] == 1'b0)
                kept.push_back('{dat: win_b[i], cmd: ~win_dc[i], last: 1'b0});
            else
                win_err = 1'b1;
        end
        if (!(close_with_last_wr && win_b.size() != 0)) begin
            dbi_csx = 1'b1;
            cyc(4);
        end
        if (kept.size() != 0) begin
            b = kept[kept.size() - 1];
            b.last = 1'b1;
            kept[kept.size() - 1] = b;
        end
        foreach (kept[i]) win_exp.push_back(kept[i]);
    endtask

    task automatic wait_beats(input int base, input int n);
        int t = 0;
        while ((got_q.size() - base) < n && t < 400) begin
            cyc(1);
            t++;
        end
        cyc(12);
    endtask

    task automatic test_reset;
        rst = 1'b1; dbi_d = '0; dbi_csx = 1'b1; dbi_dcx = 1'b1; dbi_wrx = 1'b1;
        dbi_rdx = 1'b1; dbi_resx = 1'b1; err_clr = 1'b0; rdy_fix = 1'b1; rdy_rand_mode = 1'b0;
        cyc(2);
        n_tests++;
        if ({rx_vld, rx_dat, rx_cmd, rx_last, hrst, err, ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b dat=%h cmd=%b last=%b hrst=%b err=%b ovf=%b, want all 0",
                     rx_vld, rx_dat, rx_cmd, rx_last, hrst, err, ovf);
        end
        rst = 1'b0;
        cyc(3);
        n_tests++;
        if (rx_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_vld_after_release: got %b want 0", rx_vld);
        end
    endtask

    task automatic test_cmd_params;
        int base = got_q.size();
        win_b = '{8'h2A, 8'h00, 8'hEF};
        win_dc = '{1'b0, 1'b1, 1'b1};
        send_window(1'b0);
        wait_beats(base, win_exp.size());
        n_tests++;
        if (got_q.size() - base !== win_exp.size()) begin
            n_fail++;
            $display("FAIL cmd_params_count: got %0d want %0d", got_q.size() - base, win_exp.size());
        end
        for (int i = 0; i < win_exp.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_tests++;
                if (got_q[base + i] !== win_exp[i]) begin
                    n_fail++;
                    $display("FAIL cmd_params_beat%0d: got %h want %h", i, got_q[base + i], win_exp[i]);
                end
            end
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL cmd_params_err: got %b want 0", err);
        end
    endtask

    task automatic test_cmd_only;
        int base = got_q.size();
        win_b = '{8'h29};
        win_dc = '{1'b0};
        send_window(1'b0);
        wait_beats(base, 1);
        n_tests++;
        if (got_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL cmd_only_count: got %0d want 1", got_q.size() - base);
        end else begin
            n_tests++;
            if (got_q[base] !== win_exp[0]) begin
                n_fail++;
                $display("FAIL cmd_only_beat: got %h want %h", got_q[base], win_exp[0]);
            end
        end
    endtask

    // Two windows: the first closes CSX together with its last WRX rise, the second is a command
    // closed the same way; both must still end with a last beat.
    task automatic test_back_to_back;
        int base = got_q.size();
        beat_t exp[$];
        win_b = '{8'h3C, 8'($urandom), 8'($urandom)};
        win_dc = '{1'b0, 1'b1, 1'b1};
        send_window(1'b1);
        foreach (win_exp[i]) exp.push_back(win_exp[i]);
        win_b = '{8'h2B};
        win_dc = '{1'b0};
        send_window(1'b1);
        foreach (win_exp[i]) exp.push_back(win_exp[i]);
        wait_beats(base, exp.size());
        n_tests++;
        if (got_q.size() - base !== exp.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want %0d", got_q.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_tests++;
                if (got_q[base + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL b2b_beat%0d: got %h want %h", i, got_q[base + i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_random;
        int base = got_q.size();
        beat_t exp[$];
        rdy_rand_mode = 1'b1;
        for (int w = 0; w < 8; w++) begin
            int np = $urandom_range(0, 3);
            win_b.delete();
            win_dc.delete();
            win_b.push_back(8'($urandom));
            win_dc.push_back(1'b0);
            for (int p = 0; p < np; p++) begin
                win_b.push_back(8'($urandom));
                win_dc.push_back($urandom_range(0, 4) != 0);
            end
            send_window(1'($urandom_range(0, 1)));
            foreach (win_exp[i]) exp.push_back(win_exp[i]);
        end
        wait_beats(base, exp.size());
        rdy_rand_mode = 1'b0;
        rdy_fix = 1'b1;
        n_tests++;
        if (got_q.size() - base !== exp.size()) begin
            n_fail++;
            $display("FAIL random_count: got %0d want %0d", got_q.size() - base, exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_tests++;
                if (got_q[base + i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL random_beat%0d: got %h want %h", i, got_q[base + i], exp[i]);
                end
            end
        end
        n_tests++;
        if ({err, ovf} !== 2'b00) begin
            n_fail++;
            $display("FAIL random_flags: got err=%b ovf=%b want 0 0", err, ovf);
        end
    endtask

    task automatic test_proto_err;
        int base = got_q.size();
        win_b = '{8'h55};
        win_dc = '{1'b1};
        send_window(1'b0);
        cyc(10);
        n_tests++;
        if (got_q.size() - base !== win_exp.size()) begin
            n_fail++;
            $display("FAIL proto_data_first_beats: got %0d want %0d", got_q.size() - base, win_exp.size());
        end
        n_tests++;
        if (err !== win_err) begin
            n_fail++;
            $display("FAIL proto_data_first_err: got %b want %b", err, win_err);
        end
        pulse_clr();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_err_clear: got %b want 0", err);
        end
        dbi_csx = 1'b0;
        cyc(4);
        dbi_rdx = 1'b0;
        cyc(4);
        dbi_rdx = 1'b1;
        cyc(4);
        dbi_csx = 1'b1;
        cyc(6);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL proto_rdx_err: got %b want 1", err);
        end
        n_tests++;
        if (got_q.size() !== base) begin
            n_fail++;
            $display("FAIL proto_rdx_beats: got %0d want 0", got_q.size() - base);
        end
        pulse_clr();
    endtask

    task automatic test_overflow;
        int base = got_q.size();
        bit exp_ovf;
        rdy_fix = 1'b0;
        win_b = '{8'h2C, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        win_dc = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send_window(1'b0);
        exp_ovf = (win_exp.size() > DEPTH);
        while (win_exp.size() > DEPTH) void'(win_exp.pop_back());
        cyc(6);
        n_tests++;
        if (ovf !== exp_ovf) begin
            n_fail++;
            $display("FAIL ovf_flag: got %b want %b", ovf, exp_ovf);
        end
        n_tests++;
        if (rx_vld !== 1'b1 || rx_dat !== 8'h2C || rx_cmd !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_head: got vld=%b dat=%h cmd=%b want 1 2c 1", rx_vld, rx_dat, rx_cmd);
        end
        rdy_fix = 1'b1;
        wait_beats(base, win_exp.size());
        n_tests++;
        if (got_q.size() - base !== win_exp.size()) begin
            n_fail++;
            $display("FAIL ovf_drain_count: got %0d want %0d", got_q.size() - base, win_exp.size());
        end
        for (int i = 0; i < win_exp.size(); i++) begin
            if (base + i < got_q.size()) begin
                n_tests++;
                if (got_q[base + i] !== win_exp[i]) begin
                    n_fail++;
                    $display("FAIL ovf_beat%0d: got %h want %h", i, got_q[base + i], win_exp[i]);
                end
            end
        end
        pulse_clr();
        n_tests++;
        if (ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b want 0", ovf);
        end
    endtask

    // RESX held low for exactly the minimum time in the middle of a window: the command already
    // proven non-last is kept, the parameter still waiting for its successor is lost.
    task automatic test_hrst;
        int base = got_q.size();
        int h0 = hrst_seen;
        beat_t want;
        dbi_csx = 1'b0;
        cyc(4);
        dbi_dcx = 1'b0; dbi_d = 8'hB0; dbi_wrx = 1'b0; cyc(4); dbi_wrx = 1'b1; cyc(4);
        dbi_dcx = 1'b1; dbi_d = 8'h11; dbi_wrx = 1'b0; cyc(4); dbi_wrx = 1'b1; cyc(4);
        dbi_resx = 1'b0;
        cyc(RMIN);
        dbi_resx = 1'b1;
        cyc(8);
        dbi_csx = 1'b1;
        cyc(4);
        wait_beats(base, 1);
        want = '{dat: 8'hB0, cmd: 1'b1, last: 1'b0};
        n_tests++;
        if (got_q.size() - base !== 1) begin
            n_fail++;
            $display("FAIL hrst_beats: got %0d want 1", got_q.size() - base);
        end else begin
            n_tests++;
            if (got_q[base] !== want) begin
                n_fail++;
                $display("FAIL hrst_beat: got %h want %h", got_q[base], want);
            end
        end
        n_tests++;
        if (hrst_seen - h0 !== 1) begin
            n_fail++;
            $display("FAIL hrst_pulse: got %0d high cycles want 1", hrst_seen - h0);
        end
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL hrst_err: got %b want 0", err);
        end
        base = got_q.size();
        win_b = '{8'h29};
        win_dc = '{1'b0};
        send_window(1'b0);
        wait_beats(base, 1);
        n_tests++;
        if (got_q.size() - base !== 1 || got_q[got_q.size() - 1] !== win_exp[0]) begin
            n_fail++;
            $display("FAIL hrst_recover: got %0d beats want 1 of %h", got_q.size() - base, win_exp[0]);
        end
    endtask

    task automatic test_hrst_short;
        int lens[2] = '{100, RMIN - 1};
        for (int k = 0; k < 2; k++) begin
            int h0 = hrst_seen;
            dbi_resx = 1'b0;
            cyc(lens[k]);
            dbi_resx = 1'b1;
            cyc(8);
            n_tests++;
            if (hrst_seen - h0 !== 0) begin
                n_fail++;
                $display("FAIL hrst_short%0d_pulse: got %0d want 0", lens[k], hrst_seen - h0);
            end
            n_tests++;
            if (err !== 1'b1) begin
                n_fail++;
                $display("FAIL hrst_short%0d_err: got %b want 1", lens[k], err);
            end
            pulse_clr();
        end
    endtask

    initial begin
        test_reset();
        test_cmd_params();
        test_cmd_only();
        test_back_to_back();
        test_random();
        test_proto_err();
        test_overflow();
        test_hrst();
        test_hrst_short();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
